// File: rtl/byteswap_burst_scheduler.sv
// byteswap_burst_scheduler
//   Runs one byteswap kernel pass. On ap_start it captures the buffer base and
//   length, then splits the buffer into AXI4 burst commands for the m00 read
//   and write masters. Processing is in place: write burst k reuses the address
//   and length of read burst k. The number of read bursts that are issued but
//   not yet write-completed is bounded, and ap_done/ap_ready pulse once every
//   write burst has been acknowledged.
//
// Ports
//   ap_clk, ap_rst_n          clock, asynchronous active-low reset
//   ap_start                  start level from the control slave
//   ap_idle                   high while in IDLE
//   ap_done, ap_ready         one-cycle end-of-run pulse (identical)
//   base_addr, xfer_bytes     beat-aligned buffer base, length in bytes
//   rd_cmd_*                  read burst command (valid/ready, addr, arlen)
//   wr_cmd_*                  write burst command (valid/ready, addr, awlen)
//   wr_burst_done             one pulse per completed write burst (B response)
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for ap_start; captures base/length when it arrives
// LOAD  | one cycle; a zero-beat run skips straight to DONE
// RUN   | read/write generators walk the buffer, completions are counted
// DONE  | ap_done/ap_ready high for one cycle, then back to IDLE

module byteswap_burst_scheduler #(
   parameter int C_ADDR_WIDTH      = 64,
   parameter int C_DATA_WIDTH      = 512,
   parameter int C_XFER_SIZE_WIDTH = 32,
   parameter int C_MAX_BURST_BEATS = 64,
   parameter int C_MAX_OUTSTANDING = 4
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst_n,
   input  logic                         ap_start,
   output logic                         ap_idle,
   output logic                         ap_done,
   output logic                         ap_ready,
   input  logic [C_ADDR_WIDTH-1:0]      base_addr,
   input  logic [C_XFER_SIZE_WIDTH-1:0] xfer_bytes,
   output logic                         rd_cmd_valid,
   input  logic                         rd_cmd_ready,
   output logic [C_ADDR_WIDTH-1:0]      rd_cmd_addr,
   output logic [7:0]                   rd_cmd_len,
   output logic                         wr_cmd_valid,
   input  logic                         wr_cmd_ready,
   output logic [C_ADDR_WIDTH-1:0]      wr_cmd_addr,
   output logic [7:0]                   wr_cmd_len,
   input  logic                         wr_burst_done
);

   localparam int AW         = C_ADDR_WIDTH;
   localparam int XW         = C_XFER_SIZE_WIDTH;
   localparam int BEAT_BYTES = C_DATA_WIDTH / 8;
   localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
   localparam int PAGE_BEATS = 4096 / BEAT_BYTES;
   localparam int PAGE_IDX_W = 12 - BEAT_SHIFT;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   rd_addr_q, rd_addr_d;
   logic [AW-1:0]   wr_addr_q, wr_addr_d;
   logic [XW-1:0]   rd_rem_q, rd_rem_d;
   logic [XW-1:0]   wr_rem_q, wr_rem_d;
   logic [XW-1:0]   rd_issued_q, rd_issued_d;
   logic [XW-1:0]   wr_issued_q, wr_issued_d;
   logic [XW-1:0]   wr_completed_q, wr_completed_d;

   logic [8:0]      rd_beats, wr_beats;
   logic [XW-1:0]   outstanding;
   logic            rd_fire, wr_fire, b_ok;

   // Beats in the next burst: bounded by what is left, the burst limit and
   // the distance to the next 4 KiB boundary (addresses are beat-aligned, so
   // the in-page beat index is enough to find that distance).
   function automatic logic [8:0] burst_beats(input logic [XW-1:0] rem,
                                              input logic [PAGE_IDX_W-1:0] page_idx);
      logic [12:0]   page_left;
      logic [XW-1:0] b;
      page_left = 13'(PAGE_BEATS) - 13'(page_idx);
      b = rem;
      if (b > XW'(C_MAX_BURST_BEATS)) b = XW'(C_MAX_BURST_BEATS);
      if (b > XW'(page_left))         b = XW'(page_left);
      return 9'(b);
   endfunction

   assign rd_beats    = burst_beats(rd_rem_q, rd_addr_q[11:BEAT_SHIFT]);
   assign wr_beats    = burst_beats(wr_rem_q, wr_addr_q[11:BEAT_SHIFT]);
   assign outstanding = rd_issued_q - wr_completed_q;

   // Address/length come straight from registers that only move on accept,
   // so they stay stable while a command waits for ready. Valid can only
   // drop by being accepted: outstanding never grows while a read waits.
   assign rd_cmd_valid = (state_q == S_RUN) && (rd_rem_q != '0) &&
                         (outstanding < XW'(C_MAX_OUTSTANDING));
   assign wr_cmd_valid = (state_q == S_RUN) && (wr_issued_q < rd_issued_q);
   assign rd_cmd_addr  = rd_addr_q;
   assign wr_cmd_addr  = wr_addr_q;
   assign rd_cmd_len   = (rd_rem_q != '0) ? 8'(rd_beats - 9'd1) : 8'd0;
   assign wr_cmd_len   = (wr_rem_q != '0) ? 8'(wr_beats - 9'd1) : 8'd0;

   assign ap_idle  = (state_q == S_IDLE);
   assign ap_done  = (state_q == S_DONE);
   assign ap_ready = (state_q == S_DONE);

   assign rd_fire = rd_cmd_valid && rd_cmd_ready;
   assign wr_fire = wr_cmd_valid && wr_cmd_ready;
   // A completion with no write in flight is a stray pulse and is dropped.
   assign b_ok    = (state_q == S_RUN) && wr_burst_done &&
                    (wr_completed_q < wr_issued_q);

   always_comb begin
      state_d        = state_q;
      rd_addr_d      = rd_addr_q;
      wr_addr_d      = wr_addr_q;
      rd_rem_d       = rd_rem_q;
      wr_rem_d       = wr_rem_q;
      rd_issued_d    = rd_issued_q;
      wr_issued_d    = wr_issued_q;
      wr_completed_d = wr_completed_q;

      case (state_q)
         S_IDLE: begin
            if (ap_start) begin
               rd_addr_d      = base_addr;
               wr_addr_d      = base_addr;
               rd_rem_d       = xfer_bytes >> BEAT_SHIFT;
               wr_rem_d       = xfer_bytes >> BEAT_SHIFT;
               rd_issued_d    = '0;
               wr_issued_d    = '0;
               wr_completed_d = '0;
               state_d        = S_LOAD;
            end
         end
         S_LOAD: begin
            state_d = (rd_rem_q == '0) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            if (rd_fire) begin
               rd_addr_d   = rd_addr_q + (AW'(rd_beats) << BEAT_SHIFT);
               rd_rem_d    = rd_rem_q - XW'(rd_beats);
               rd_issued_d = rd_issued_q + 1'b1;
            end
            if (wr_fire) begin
               wr_addr_d   = wr_addr_q + (AW'(wr_beats) << BEAT_SHIFT);
               wr_rem_d    = wr_rem_q - XW'(wr_beats);
               wr_issued_d = wr_issued_q + 1'b1;
            end
            if (b_ok) wr_completed_d = wr_completed_q + 1'b1;
            // Evaluated on next-state counts so ap_done follows the final
            // completion by one cycle.
            if ((rd_rem_d == '0) && (wr_issued_d == rd_issued_d) &&
                (wr_completed_d == wr_issued_d)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q        <= S_IDLE;
         rd_addr_q      <= '0;
         wr_addr_q      <= '0;
         rd_rem_q       <= '0;
         wr_rem_q       <= '0;
         rd_issued_q    <= '0;
         wr_issued_q    <= '0;
         wr_completed_q <= '0;
      end else begin
         state_q        <= state_d;
         rd_addr_q      <= rd_addr_d;
         wr_addr_q      <= wr_addr_d;
         rd_rem_q       <= rd_rem_d;
         wr_rem_q       <= wr_rem_d;
         rd_issued_q    <= rd_issued_d;
         wr_issued_q    <= wr_issued_d;
         wr_completed_q <= wr_completed_d;
      end
   end

endmodule

// File: tb/tb_byteswap_burst_scheduler.sv
// Testbench for byteswap_burst_scheduler: directed runs with hand-computed
// burst lists, outstanding-limit and handshake-stability scenarios, and an
// asynchronous reset in the middle of a run.

module tb_byteswap_burst_scheduler;

   localparam int AW = 64;
   localparam int XW = 32;

   logic          ap_clk = 1'b0;
   logic          ap_rst_n = 1'b1;
   logic          ap_start = 1'b0;
   logic          ap_idle, ap_done, ap_ready;
   logic [AW-1:0] base_addr = '0;
   logic [XW-1:0] xfer_bytes = '0;
   logic          rd_cmd_valid;
   logic          rd_cmd_ready = 1'b0;
   logic [AW-1:0] rd_cmd_addr;
   logic [7:0]    rd_cmd_len;
   logic          wr_cmd_valid;
   logic          wr_cmd_ready = 1'b0;
   logic [AW-1:0] wr_cmd_addr;
   logic [7:0]    wr_cmd_len;
   logic          wr_burst_done;
   logic          b_auto = 1'b0;
   logic          b_man = 1'b0;
   logic          auto_en = 1'b0;

   assign wr_burst_done = b_auto | b_man;

   byteswap_burst_scheduler dut (
      .ap_clk        (ap_clk),
      .ap_rst_n      (ap_rst_n),
      .ap_start      (ap_start),
      .ap_idle       (ap_idle),
      .ap_done       (ap_done),
      .ap_ready      (ap_ready),
      .base_addr     (base_addr),
      .xfer_bytes    (xfer_bytes),
      .rd_cmd_valid  (rd_cmd_valid),
      .rd_cmd_ready  (rd_cmd_ready),
      .rd_cmd_addr   (rd_cmd_addr),
      .rd_cmd_len    (rd_cmd_len),
      .wr_cmd_valid  (wr_cmd_valid),
      .wr_cmd_ready  (wr_cmd_ready),
      .wr_cmd_addr   (wr_cmd_addr),
      .wr_cmd_len    (wr_cmd_len),
      .wr_burst_done (wr_burst_done)
   );

   always #5 ap_clk = ~ap_clk;

   int unsigned cyc = 0;
   int unsigned last_b_cyc = 0;
   int unsigned done_cyc = 0;
   logic [71:0] rd_log[$];
   logic [71:0] wr_log[$];
   int unsigned b_due[$];
   int          n_checks = 0;
   int          n_fail = 0;

   // Records accepted commands and, when enabled, answers each accepted write
   // with a completion pulse three cycles later.
   always @(posedge ap_clk) begin
      cyc    <= cyc + 1;
      b_auto <= 1'b0;
      if (!ap_rst_n) begin
         b_due.delete();
      end else begin
         if (rd_cmd_valid && rd_cmd_ready) rd_log.push_back({rd_cmd_addr, rd_cmd_len});
         if (wr_cmd_valid && wr_cmd_ready) begin
            wr_log.push_back({wr_cmd_addr, wr_cmd_len});
            if (auto_en) b_due.push_back(cyc + 3);
         end
         if (b_due.size() > 0 && b_due[0] == cyc) begin
            b_auto <= 1'b1;
            void'(b_due.pop_front());
         end
         if (wr_burst_done) last_b_cyc <= cyc;
         if (ap_done) done_cyc <= cyc;
      end
   end

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start_run(input logic [AW-1:0] base, input logic [XW-1:0] bytes);
      @(posedge ap_clk); #1;
      base_addr  = base;
      xfer_bytes = bytes;
      ap_start   = 1'b1;
      @(posedge ap_clk); #1;
      ap_start   = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge ap_clk);
         if (ap_done) begin
            ok = 1'b1;
            break;
         end
      end
      chk({tag, "_done_seen"}, 72'(ok), 72'd1);
   endtask

   task automatic pulse_b();
      @(posedge ap_clk); #1;
      b_man = 1'b1;
      @(posedge ap_clk); #1;
      b_man = 1'b0;
   endtask

   task automatic check_pair(input string tag, input int r0, input int w0,
                             input logic [71:0] e0, input logic [71:0] e1);
      chk({tag, "_rd_n"}, 72'(rd_log.size() - r0), 72'd2);
      chk({tag, "_rd0"},  rd_log[r0],     e0);
      chk({tag, "_rd1"},  rd_log[r0 + 1], e1);
      chk({tag, "_wr_n"}, 72'(wr_log.size() - w0), 72'd2);
      chk({tag, "_wr0"},  wr_log[w0],     e0);
      chk({tag, "_wr1"},  wr_log[w0 + 1], e1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, w0;

      #2 ap_rst_n = 1'b0;
      repeat (3) @(posedge ap_clk);
      @(negedge ap_clk);
      chk("rst_idle",    72'(ap_idle), 72'd1);
      chk("rst_done",    72'(ap_done), 72'd0);
      chk("rst_ready",   72'(ap_ready), 72'd0);
      chk("rst_rdv",     72'(rd_cmd_valid), 72'd0);
      chk("rst_wrv",     72'(wr_cmd_valid), 72'd0);
      chk("rst_rd_addr", 72'(rd_cmd_addr), 72'd0);
      chk("rst_rd_len",  72'(rd_cmd_len), 72'd0);
      chk("rst_wr_addr", 72'(wr_cmd_addr), 72'd0);
      chk("rst_wr_len",  72'(wr_cmd_len), 72'd0);
      ap_rst_n     = 1'b1;
      rd_cmd_ready = 1'b1;
      wr_cmd_ready = 1'b1;

      // zero-length run: LOAD then a single DONE cycle, no commands
      r0 = rd_log.size(); w0 = wr_log.size();
      start_run(64'h0, 32'd0);
      @(negedge ap_clk);
      chk("c1_load_idle", 72'(ap_idle), 72'd0);
      chk("c1_load_done", 72'(ap_done), 72'd0);
      @(negedge ap_clk);
      chk("c1_done",  72'(ap_done), 72'd1);
      chk("c1_ready", 72'(ap_ready), 72'd1);
      chk("c1_rdv",   72'(rd_cmd_valid), 72'd0);
      @(negedge ap_clk);
      chk("c1_done_off", 72'(ap_done), 72'd0);
      chk("c1_idle",     72'(ap_idle), 72'd1);
      chk("c1_no_cmd", 72'((rd_log.size() - r0) + (wr_log.size() - w0)), 72'd0);

      // two full 64-beat bursts, completions answered automatically
      auto_en = 1'b1;
      r0 = rd_log.size(); w0 = wr_log.size();
      start_run(64'h1000, 32'd8192);
      @(negedge ap_clk);
      chk("c2_lat_load", 72'(rd_cmd_valid), 72'd0);
      @(negedge ap_clk);
      chk("c2_lat_run",  72'(rd_cmd_valid), 72'd1);
      wait_done("c2", 200);
      @(negedge ap_clk);
      chk("c2_idle_after", 72'(ap_idle), 72'd1);
      chk("c2_done_lat", 72'(done_cyc), 72'(last_b_cyc + 1));
      check_pair("c2", r0, w0, {64'h1000, 8'd63}, {64'h2000, 8'd63});

      // split at the 4 KiB boundary: 2 beats then 8 beats
      r0 = rd_log.size(); w0 = wr_log.size();
      start_run(64'h1F80, 32'd640);
      wait_done("c3", 200);
      check_pair("c3", r0, w0, {64'h1F80, 8'd1}, {64'h2000, 8'd7});

      // outstanding limit with completions held back
      auto_en = 1'b0;
      r0 = rd_log.size(); w0 = wr_log.size();
      start_run(64'h0, 32'd24576);
      repeat (20) @(negedge ap_clk);
      chk("c4_rd_cap",      72'(rd_log.size() - r0), 72'd4);
      chk("c4_rdv_blocked", 72'(rd_cmd_valid), 72'd0);
      chk("c4_wr_n",        72'(wr_log.size() - w0), 72'd4);
      rd_cmd_ready = 1'b0;
      pulse_b();
      @(negedge ap_clk);
      chk("c4_rdv_open", 72'(rd_cmd_valid), 72'd1);
      @(posedge ap_clk); #1;
      rd_cmd_ready = 1'b1;
      b_man        = 1'b1;
      @(posedge ap_clk); #1;
      rd_cmd_ready = 1'b0;
      b_man        = 1'b0;
      @(negedge ap_clk);
      chk("c4_rd5",       72'(rd_log.size() - r0), 72'd5);
      chk("c4_rd5_addr",  rd_log[r0 + 4], {64'h4000, 8'd63});
      chk("c4_sim_rdv",   72'(rd_cmd_valid), 72'd1);
      rd_cmd_ready = 1'b1;
      repeat (3) @(negedge ap_clk);
      chk("c4_rd6",       72'(rd_log.size() - r0), 72'd6);
      chk("c4_rdv_full",  72'(rd_cmd_valid), 72'd0);
      chk("c4_no_done",   72'(ap_done), 72'd0);
      repeat (4) pulse_b();
      wait_done("c4", 10);
      chk("c4_wr_total",  72'(wr_log.size() - w0), 72'd6);

      // read command held while ready is low; ap_start during RUN ignored
      auto_en      = 1'b1;
      rd_cmd_ready = 1'b0;
      r0 = rd_log.size(); w0 = wr_log.size();
      start_run(64'h1000, 32'd8192);
      repeat (2) @(negedge ap_clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge ap_clk);
         chk($sformatf("c5_hold_v%0d", i), 72'(rd_cmd_valid), 72'd1);
         chk($sformatf("c5_hold_a%0d", i), 72'(rd_cmd_addr), 72'h1000);
         chk($sformatf("c5_hold_l%0d", i), 72'(rd_cmd_len), 72'd63);
         ap_start = (i == 1 || i == 2);
      end
      ap_start = 1'b0;
      @(posedge ap_clk); #1;
      rd_cmd_ready = 1'b1;
      wait_done("c5", 200);
      repeat (3) @(negedge ap_clk);
      chk("c5_idle_after", 72'(ap_idle), 72'd1);
      check_pair("c5", r0, w0, {64'h1000, 8'd63}, {64'h2000, 8'd63});

      // asynchronous reset in the middle of a run, then a clean rerun
      start_run(64'h1000, 32'd8192);
      repeat (3) @(negedge ap_clk);
      #2 ap_rst_n = 1'b0;
      #1;
      chk("c6_idle",    72'(ap_idle), 72'd1);
      chk("c6_rdv",     72'(rd_cmd_valid), 72'd0);
      chk("c6_wrv",     72'(wr_cmd_valid), 72'd0);
      chk("c6_rd_addr", 72'(rd_cmd_addr), 72'd0);
      chk("c6_rd_len",  72'(rd_cmd_len), 72'd0);
      chk("c6_wr_addr", 72'(wr_cmd_addr), 72'd0);
      chk("c6_done",    72'(ap_done), 72'd0);
      repeat (2) @(posedge ap_clk);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      chk("c6_idle_rel", 72'(ap_idle), 72'd1);
      r0 = rd_log.size(); w0 = wr_log.size();
      start_run(64'h1000, 32'd8192);
      wait_done("c6", 200);
      check_pair("c6", r0, w0, {64'h1000, 8'd63}, {64'h2000, 8'd63});

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
